regfile_mp_bypass: RTL and testbench

//  Parametrised multi-port register file for the 5-stage MIPS pipeline; replaces the 2R/1W negedge-write file.

---
 rtl/mips_pkg.sv | 6 +
 rtl/regfile_rd_port.sv | 26 ++
 rtl/regfile_mp_bypass.sv | 55 +++++
 tb/tb_regfile_mp_bypass.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file defaults (data width, address width, hardwired-zero register index)
package mips_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port; stored-value mux, priority bypass of same-cycle writes, zero-register and reset gating to 0
module regfile_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                                reset,
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    mem,
  input  logic [NUM_WR-1:0]                   wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]            wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]                   data
);
  logic [DATA_W-1:0] fwd;
  always_comb begin
    fwd = mem[addr];
    for (int w = 0; w < NUM_WR; w++)
      if (BYPASS != 0 && wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) fwd = wr_data[w*DATA_W +: DATA_W];
    data = (reset || (ZERO_REG != 0 && addr == ADDR_W'(REG_ZERO))) ? '0 : fwd;
  end
endmodule

// File: rtl/regfile_mp_bypass.sv
// regfile_mp_bypass: multi-port register file (clk, async reset, rd_addr/rd_data x NUM_RD, wr_en/wr_addr/wr_data x NUM_WR, registered wr_conflict)
module regfile_mp_bypass
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_conflict
);
  logic [2**ADDR_W-1:0][DATA_W-1:0] mem;
  logic conflict;
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_en[i] && wr_en[j] && wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]) conflict = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem         <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)))
          mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
      wr_conflict <= conflict;
    end
  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_rd_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
      ) u_rd (
        .reset  (reset),
        .addr   (rd_addr[p*ADDR_W +: ADDR_W]),
        .mem    (mem),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .data   (rd_data[p*DATA_W +: DATA_W])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp_bypass.sv
// tb_regfile_mp_bypass: bypass and non-bypass register files driven in parallel and checked against an array model
module tb_regfile_mp_bypass;
  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [95:0] rd_data_b, rd_data_n;
  logic        conf_b, conf_n;
  logic [31:0] m [32];
  logic        mconf;
  int          pass_cnt = 0;
  int          total = 0;
  always #5 clk = ~clk;
  regfile_mp_bypass #(.NUM_RD(3), .NUM_WR(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_conflict(conf_b)
  );
  regfile_mp_bypass #(.NUM_RD(3), .NUM_WR(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_conflict(conf_n)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    logic [31:0] r;
    if (reset || a == 5'd0) return 32'd0;
    r = m[a];
    if (byp) begin
      if (wr_en[0] && wr_addr[4:0] == a) r = wr_data[31:0];
      if (wr_en[1] && wr_addr[9:5] == a) r = wr_data[63:32];
    end
    return r;
  endfunction
  task automatic clear_model();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    mconf = 1'b0;
  endtask
  task automatic check_all();
    #1;
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("byp_rd%0d", p), rd_data_b[p*32 +: 32], exp_rd(rd_addr[p*5 +: 5], 1'b1));
      chk($sformatf("nobyp_rd%0d", p), rd_data_n[p*32 +: 32], exp_rd(rd_addr[p*5 +: 5], 1'b0));
    end
    chk("byp_conflict", {31'd0, conf_b}, {31'd0, mconf});
    chk("nobyp_conflict", {31'd0, conf_n}, {31'd0, mconf});
  endtask
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      mconf = wr_en[0] && wr_en[1] && wr_addr[4:0] == wr_addr[9:5];
      if (wr_en[0] && wr_addr[4:0] != 5'd0) m[wr_addr[4:0]] = wr_data[31:0];
      if (wr_en[1] && wr_addr[9:5] != 5'd0) m[wr_addr[9:5]] = wr_data[63:32];
    end
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    clear_model();
    @(negedge clk); @(negedge clk);
    check_all();
    reset = 1'b0;
    check_all();
    for (int a = 1; a < 32; a++) begin
      wr_en = 2'b01; wr_addr = {5'd0, 5'(a)}; wr_data = {32'd0, 32'hFFFF_FFFF};
      rd_addr = {5'(a), 5'(a), 5'(a)};
      check_all();
      tick();
    end
    wr_en = 2'b00; rd_addr = {5'd17, 5'd1, 5'd31};
    check_all();
    chk("fill_r31", rd_data_n[31:0], 32'hFFFF_FFFF);
    reset = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'h55};
    clear_model();
    check_all();
    chk("reset_imm_rd0", rd_data_b[31:0], 32'd0);
    tick();
    reset = 1'b0; wr_en = 2'b00; rd_addr = {5'd5, 5'd1, 5'd31};
    check_all();
    chk("reset_after_r31", rd_data_n[31:0], 32'd0);
    chk("reset_after_r5", rd_data_n[95:64], 32'd0);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd8}; wr_data = {32'd0, 32'hDEAD_BEEF}; rd_addr = {5'd0, 5'd0, 5'd8};
    check_all();
    chk("bypass_same_cycle", rd_data_b[31:0], 32'hDEAD_BEEF);
    chk("nobypass_old", rd_data_n[31:0], 32'd0);
    tick();
    wr_en = 2'b00;
    check_all();
    chk("nobypass_next", rd_data_n[31:0], 32'hDEAD_BEEF);
    wr_en = 2'b01; wr_addr = '0; wr_data = {32'd0, 32'h1234}; rd_addr = '0;
    check_all();
    chk("r0_same", rd_data_b[63:32], 32'd0);
    tick();
    wr_en = 2'b00;
    check_all();
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h2222, 32'h1111}; rd_addr = {5'd5, 5'd5, 5'd5};
    check_all();
    chk("prio_bypass", rd_data_b[31:0], 32'h2222);
    tick();
    wr_en = 2'b00;
    check_all();
    chk("prio_stored", rd_data_n[63:32], 32'h2222);
    chk("conflict_high", {31'd0, conf_b}, 32'd1);
    tick();
    check_all();
    chk("conflict_low", {31'd0, conf_b}, 32'd0);
    wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'h77, 32'h66};
    tick();
    wr_en = 2'b00; rd_addr = '0;
    check_all();
    chk("conflict_r0", {31'd0, conf_n}, 32'd1);
    wr_en = 2'b11; wr_addr = {5'd4, 5'd3}; wr_data = {32'd9, 32'd7};
    tick();
    wr_en = 2'b00; rd_addr = {5'd3, 5'd4, 5'd3};
    check_all();
    chk("multi_rd", rd_data_b[31:0] + rd_data_b[63:32] * 32'd16 + rd_data_b[95:64] * 32'd256, 32'h797);
    wr_en = 2'b10; wr_addr = {5'd31, 5'd0}; wr_data = {32'h8000_0000, 32'd0};
    tick();
    wr_en = 2'b00; rd_addr = {5'd31, 5'd31, 5'd0};
    check_all();
    chk("r31_top", rd_data_n[95:64], 32'h8000_0000);
    chk("r31_no_alias", rd_data_n[31:0], 32'd0);
    for (int k = 0; k < 400; k++) begin
      wr_en = 2'($urandom);
      wr_addr = {($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      rd_addr = {5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if (k % 97 == 50) begin
        reset = 1'b1;
        clear_model();
      end
      check_all();
      tick();
      reset = 1'b0;
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
